// File: rtl/fb_if_stage_pkg.sv
// ============================================================================
//  Module  : fb_if_stage_pkg
//  Brief   : Shared constants and FSM encoding for the Firebird IF stage.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fb_if_stage_pkg;

    localparam int          FB_32BITS      = 32;
    localparam logic [31:0] FB_BUBBLE_INST = 32'b0;

    typedef enum logic [0:0] {
        FB_IF_RUN    = 1'b0,
        FB_IF_LOCKED = 1'b1
    } fb_if_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_if_stage_if_id.sv
// ============================================================================
//  Module  : fb_if_id_reg
//  Brief   : IF/ID pipeline register with hold and bubble insertion.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_if_id_reg
    import fb_if_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 bubble,
    input  logic [FB_32BITS-1:0] pc_in,
    input  logic [FB_32BITS-1:0] inst_in,
    output logic [FB_32BITS-1:0] pc,
    output logic [FB_32BITS-1:0] inst,
    output logic                 valid
);

    // Bubble wins over hold so a flush still lands while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            inst  <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            pc    <= pc_in;
            inst  <= FB_BUBBLE_INST;
            valid <= 1'b0;
        end else if (!hold) begin
            pc    <= pc_in;
            inst  <= inst_in;
            valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fb_if_stage.sv
// ============================================================================
//  Module  : fb_if_stage
//  Brief   : Firebird instruction fetch: PC register, next-PC select, JALR
//            lock FSM, IF/ID register and saturating flush/lock counters.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_if_stage
    import fb_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic                 address_src,
    input  logic [FB_32BITS-1:0] predict_pc,
    input  logic [FB_32BITS-1:0] predict_err_pc,
    input  logic                 register_rst,
    input  logic                 lock,
    output logic [FB_32BITS-1:0] imem_addr,
    input  logic [FB_32BITS-1:0] imem_rdata,
    output logic [FB_32BITS-1:0] if_pc,
    output logic [FB_32BITS-1:0] if_inst,
    output logic [FB_32BITS-1:0] id_pc,
    output logic [FB_32BITS-1:0] id_inst,
    output logic                 id_valid,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     lock_cnt
);

    fb_if_state_t         r_state;
    fb_if_state_t         w_state_nxt;
    logic [FB_32BITS-1:0] r_pc;
    logic [FB_32BITS-1:0] w_pc_nxt;
    logic [FB_32BITS-1:0] w_pc_plus1;
    logic                 w_bubble;
    logic                 w_lock_inc;

    assign w_pc_plus1 = r_pc + 32'd1;
    assign imem_addr  = r_pc;
    assign if_pc      = r_pc;
    assign if_inst    = imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FB_IF_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_bubble    = 1'b0;
        w_lock_inc  = 1'b0;
        if (register_rst) begin
            w_pc_nxt    = predict_err_pc;
            w_bubble    = 1'b1;
            w_state_nxt = FB_IF_RUN;
        end else if (stall) begin
            w_state_nxt = r_state;
        end else if (r_state == FB_IF_LOCKED) begin
            // The JALR copy still in IF is dropped; its target is now known.
            w_bubble    = 1'b1;
            w_pc_nxt    = pc_src ? predict_pc : w_pc_plus1;
            w_state_nxt = FB_IF_RUN;
        end else if (lock) begin
            w_lock_inc  = 1'b1;
            w_state_nxt = FB_IF_LOCKED;
        end else begin
            w_pc_nxt = pc_src ? (address_src ? predict_err_pc : predict_pc)
                              : w_pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            lock_cnt  <= '0;
        end else begin
            if (register_rst && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (w_lock_inc && (lock_cnt != {CNT_W{1'b1}}))
                lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    fb_if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .hold    (stall),
        .bubble  (w_bubble),
        .pc_in   (r_pc),
        .inst_in (imem_rdata),
        .pc      (id_pc),
        .inst    (id_inst),
        .valid   (id_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_fb_if_stage.sv
// ============================================================================
//  Module  : tb_fb_if_stage
//  Brief   : Directed self-checking bench for fb_if_stage.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic        address_src = 1'b0;
    logic [31:0] predict_pc = '0;
    logic [31:0] predict_err_pc = '0;
    logic        register_rst = 1'b0;
    logic        lock = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [15:0] flush_cnt;
    logic [15:0] lock_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: tagged word so real fetches are never zero.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    fb_if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc_src         (pc_src),
        .address_src    (address_src),
        .predict_pc     (predict_pc),
        .predict_err_pc (predict_err_pc),
        .register_rst   (register_rst),
        .lock           (lock),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_valid       (id_valid),
        .flush_cnt      (flush_cnt),
        .lock_cnt       (lock_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp %h", imem_addr, 32'h0); end
        checks++; if ({id_pc, id_inst, id_valid} !== 65'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h/%b exp 0/0/0", id_pc, id_inst, id_valid); end
        checks++; if ({flush_cnt, lock_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h exp 0/0", flush_cnt, lock_cnt); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_seq_fetch();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0: got %h exp %h", imem_addr, 32'h0); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'(i)) begin errors++; $display("FAIL seq_addr: got %h exp %h", imem_addr, 32'(i)); end
            checks++; if (id_pc !== 32'(i-1) || id_valid !== 1'b1) begin errors++; $display("FAIL seq_idpc: got %h/%b exp %h/1", id_pc, id_valid, 32'(i-1)); end
            checks++; if (id_inst !== {16'hC0DE, 16'(i-1)}) begin errors++; $display("FAIL seq_inst: got %h exp %h", id_inst, {16'hC0DE, 16'(i-1)}); end
        end
        checks++; if (if_inst !== 32'hC0DE_0003) begin errors++; $display("FAIL if_inst: got %h exp %h", if_inst, 32'hC0DE_0003); end
    endtask

    task automatic test_jal();
        step(); step();
        checks++; if (if_pc !== 32'h5) begin errors++; $display("FAIL jal_pre: got %h exp %h", if_pc, 32'h5); end
        pc_src = 1'b1; predict_pc = 32'h20;
        step();
        pc_src = 1'b0;
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL jal_addr: got %h exp %h", imem_addr, 32'h20); end
        checks++; if (id_pc !== 32'h5 || id_valid !== 1'b1 || id_inst !== 32'hC0DE_0005) begin errors++; $display("FAIL jal_ifid: got %h/%h/%b exp 5/c0de0005/1", id_pc, id_inst, id_valid); end
    endtask

    task automatic test_flush();
        register_rst = 1'b1; address_src = 1'b1; predict_err_pc = 32'h40; stall = 1'b1;
        step();
        register_rst = 1'b0; address_src = 1'b0; stall = 1'b0;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL flush_addr: got %h exp %h", imem_addr, 32'h40); end
        checks++; if (id_inst !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h20) begin errors++; $display("FAIL flush_ifid: got %h/%h/%b exp 20/0/0", id_pc, id_inst, id_valid); end
        checks++; if (flush_cnt !== 16'h1) begin errors++; $display("FAIL flush_cnt: got %h exp %h", flush_cnt, 16'h1); end
    endtask

    task automatic test_jalr_lock();
        pc_src = 1'b1; predict_pc = 32'h8;
        step();
        pc_src = 1'b0; lock = 1'b1;
        step();
        checks++; if (id_pc !== 32'h8 || id_valid !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL jalr_e1: got idpc %h v %b addr %h exp 8/1/8", id_pc, id_valid, imem_addr); end
        checks++; if (lock_cnt !== 16'h1) begin errors++; $display("FAIL jalr_cnt1: got %h exp %h", lock_cnt, 16'h1); end
        pc_src = 1'b1; predict_pc = 32'h100;
        step();
        lock = 1'b0; pc_src = 1'b0;
        checks++; if (id_inst !== 32'h0 || id_valid !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL jalr_e2: got inst %h v %b addr %h exp 0/0/100", id_inst, id_valid, imem_addr); end
        checks++; if (lock_cnt !== 16'h1) begin errors++; $display("FAIL jalr_cnt2: got %h exp %h", lock_cnt, 16'h1); end
        step();
        checks++; if (id_pc !== 32'h100 || id_valid !== 1'b1 || imem_addr !== 32'h101) begin errors++; $display("FAIL jalr_resume: got idpc %h v %b addr %h exp 100/1/101", id_pc, id_valid, imem_addr); end
    endtask

    task automatic test_stall_locked();
        lock = 1'b1;
        step();
        lock = 1'b0; stall = 1'b1; pc_src = 1'b1; predict_pc = 32'h200;
        checks++; if (lock_cnt !== 16'h2) begin errors++; $display("FAIL stl_cnt: got %h exp %h", lock_cnt, 16'h2); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'h101 || id_pc !== 32'h101 || id_valid !== 1'b1) begin errors++; $display("FAIL stl_hold: got addr %h idpc %h v %b exp 101/101/1", imem_addr, id_pc, id_valid); end
        end
        stall = 1'b0;
        step();
        pc_src = 1'b0;
        checks++; if (imem_addr !== 32'h200 || id_valid !== 1'b0 || id_inst !== 32'h0) begin errors++; $display("FAIL stl_release: got addr %h v %b inst %h exp 200/0/0", imem_addr, id_valid, id_inst); end
        checks++; if (lock_cnt !== 16'h2) begin errors++; $display("FAIL stl_cnt2: got %h exp %h", lock_cnt, 16'h2); end
    endtask

    task automatic test_wrap();
        pc_src = 1'b1; predict_pc = 32'hFFFF_FFFF;
        step();
        pc_src = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h exp %h", imem_addr, 32'h0); end
        checks++; if (id_pc !== 32'hFFFF_FFFF || id_inst !== 32'hC0DE_FFFF) begin errors++; $display("FAIL wrap_ifid: got %h/%h exp ffffffff/c0deffff", id_pc, id_inst); end
    endtask

    task automatic test_flush_sat();
        register_rst = 1'b1; predict_err_pc = 32'h10;
        repeat (65533) @(posedge clk);
        #1;
        checks++; if (flush_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h exp %h", flush_cnt, 16'hFFFE); end
        step();
        checks++; if (flush_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max: got %h exp %h", flush_cnt, 16'hFFFF); end
        step();
        register_rst = 1'b0;
        checks++; if (flush_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h exp %h", flush_cnt, 16'hFFFF); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL sat_addr: got %h exp %h", imem_addr, 32'h10); end
    endtask

    task automatic test_rst_locked();
        lock = 1'b1;
        step();
        lock = 1'b0; pc_src = 1'b1; predict_pc = 32'h300;
        checks++; if (id_pc !== 32'h10 || id_valid !== 1'b1 || lock_cnt !== 16'h3) begin errors++; $display("FAIL rl_lock: got idpc %h v %b cnt %h exp 10/1/3", id_pc, id_valid, lock_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL rl_pc: got %h exp %h", imem_addr, 32'h0); end
        checks++; if ({id_pc, id_inst, id_valid} !== 65'h0) begin errors++; $display("FAIL rl_ifid: got %h/%h/%b exp 0/0/0", id_pc, id_inst, id_valid); end
        checks++; if ({flush_cnt, lock_cnt} !== 32'h0) begin errors++; $display("FAIL rl_cnt: got %h/%h exp 0/0", flush_cnt, lock_cnt); end
        step();
        rst = 1'b0; pc_src = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h1 || id_pc !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL rl_run: got addr %h idpc %h v %b exp 1/0/1", imem_addr, id_pc, id_valid); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_jal();
        test_flush();
        test_jalr_lock();
        test_stall_locked();
        test_wrap();
        test_flush_sat();
        test_rst_locked();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
